// File: rtl/lfsr_word.sv
`default_nettype none
// ============================================================================
// Module   : lfsr_word
// Purpose  : Fibonacci LFSR that packs its bit stream into WORD_BITS-wide
//            words behind a valid/ready output, with seed reload, zero-lock
//            recovery and a pulse each time the state returns to the seed.
// Revision : 1.0 - initial release
// ============================================================================
module lfsr_word #(
  parameter int unsigned          NUM_BITS  = 16,
  parameter logic [NUM_BITS-1:0]  TAPS      = 16'hD008,
  parameter logic [NUM_BITS-1:0]  SEED      = 16'h0001,
  parameter int unsigned          WORD_BITS = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 seed_load,
  input  logic [NUM_BITS-1:0]  seed_in,
  output logic [WORD_BITS-1:0] out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 wrap
);

  // A one-bit counter is kept even for single-bit words so the compare below
  // stays well formed; it simply never leaves zero.
  localparam int unsigned       CNT_W    = (WORD_BITS > 1) ? $clog2(WORD_BITS) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WORD_BITS - 1);

  logic [NUM_BITS-1:0]  sr;
  logic [NUM_BITS-1:0]  ref_seed;
  logic [CNT_W-1:0]     cnt;

  logic                 fb;
  logic                 emit;
  logic                 last;
  logic                 step;
  logic [NUM_BITS-1:0]  sr_next;
  logic [NUM_BITS-1:0]  seed_eff;
  logic [WORD_BITS-1:0] word_next;

  assign fb   = ^(sr & TAPS);
  assign emit = sr[NUM_BITS-1];
  assign last = (cnt == CNT_LAST);

  // Only the completing shift needs a free output slot; earlier bits of a
  // word can always be buffered in the assembly register.
  assign step = en && !seed_load && (!last || !out_valid || out_ready);

  // An all-zero state would lock up forever, so it is steered back to SEED.
  assign sr_next  = (sr == '0) ? SEED : {sr[NUM_BITS-2:0], fb};
  assign seed_eff = (seed_in == '0) ? SEED : seed_in;

  // The partial word is only meaningful when a word holds more than one bit.
  generate
    if (WORD_BITS == 1) begin : g_single
      assign word_next = emit;
    end else begin : g_multi
      // Bits already emitted for the word under construction, oldest at MSB.
      logic [WORD_BITS-2:0] asm_word;

      assign word_next = {asm_word, emit};

      // Collect emitted bits; a seed reload discards the partial word.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          asm_word <= '0;
        end else if (seed_load) begin
          asm_word <= '0;
        end else if (step) begin
          asm_word <= word_next[WORD_BITS-2:0];
        end
      end
    end
  endgenerate

  // Generator state: shift register, reference seed and bit counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr       <= SEED;
      ref_seed <= SEED;
      cnt      <= '0;
    end else if (seed_load) begin
      sr       <= seed_eff;
      ref_seed <= seed_eff;
      cnt      <= '0;
    end else if (step) begin
      sr  <= sr_next;
      cnt <= last ? '0 : cnt + CNT_W'(1);
    end
  end

  // Output word slot: a completing shift refills it even while the old word
  // is being consumed, so a continuous stream has no bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data  <= '0;
      out_valid <= 1'b0;
    end else if (step && last) begin
      out_data  <= word_next;
      out_valid <= 1'b1;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Period marker: flags the cycle after a shift lands back on the seed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrap <= 1'b0;
    end else begin
      wrap <= step && (sr_next == ref_seed);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_lfsr_word.sv
`default_nettype none
// ============================================================================
// Module   : tb_lfsr_word
// Purpose  : Bench for lfsr_word: directed scenarios plus randomized traffic
//            compared against a bit-stream reference model, and a short
//            4-bit maximal-length instance for period checks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lfsr_word;

  localparam int          N    = 16;
  localparam int          W    = 8;
  localparam logic [15:0] TAPS = 16'hD008;
  localparam logic [15:0] SEED = 16'h0001;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        seed_load = 1'b0;
  logic [15:0] seed_in = '0;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        wrap;

  logic        rst_n_s = 1'b0;
  logic        en_s = 1'b0;
  logic        ld_s = 1'b0;
  logic [3:0]  seed_s = 4'h0;
  logic [0:0]  data_s;
  logic        valid_s;
  logic        rdy_s = 1'b0;
  logic        wrap_s;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: LFSR state as a number, emitted bits collected in a queue.
  logic [15:0] m_sr, m_ref;
  bit          m_part[$];
  logic        m_valid, m_wrap;
  logic [7:0]  m_data;

  always #5 clk = ~clk;

  lfsr_word dut (
    .clk(clk), .rst_n(rst_n), .en(en), .seed_load(seed_load), .seed_in(seed_in),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .wrap(wrap)
  );

  lfsr_word #(.NUM_BITS(4), .TAPS(4'hC), .SEED(4'h1), .WORD_BITS(1)) u_small (
    .clk(clk), .rst_n(rst_n_s), .en(en_s), .seed_load(ld_s), .seed_in(seed_s),
    .out_data(data_s), .out_valid(valid_s), .out_ready(rdy_s), .wrap(wrap_s)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_tests++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp_v, $time);
    end
  endtask

  // Next state: shift left, new LSB is the parity of the tapped bits.
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    if (s == 16'h0) return SEED;
    return (s << 1) | 16'($countones(s & TAPS) % 2);
  endfunction

  function automatic void model_reset();
    m_sr = SEED; m_ref = SEED; m_part.delete();
    m_valid = 1'b0; m_wrap = 1'b0; m_data = 8'h00;
  endfunction

  function automatic void model_edge(input logic e, input logic ld, input logic [15:0] sd,
                                     input logic rdy);
    bit b;
    bit adv;
    bit consumed;
    consumed = m_valid && rdy;
    m_wrap = 1'b0;
    if (ld) begin
      m_sr = (sd == 16'h0) ? SEED : sd;
      m_ref = m_sr;
      m_part.delete();
      if (consumed) m_valid = 1'b0;
    end else begin
      adv = e && (m_part.size() < W - 1 || !m_valid || rdy);
      if (adv) begin
        b = m_sr[N-1];
        m_sr = lfsr_next(m_sr);
        m_wrap = (m_sr == m_ref);
        m_part.push_back(b);
      end
      if (m_part.size() == W) begin
        m_data = 8'h00;
        foreach (m_part[i]) m_data = {m_data[6:0], m_part[i]};
        m_part.delete();
        m_valid = 1'b1;
      end else if (consumed) begin
        m_valid = 1'b0;
      end
    end
  endfunction

  task automatic cycle(input logic e, input logic ld, input logic [15:0] sd, input logic rdy);
    @(negedge clk);
    en = e; seed_load = ld; seed_in = sd; out_ready = rdy;
    @(posedge clk);
    model_edge(e, ld, sd, rdy);
    #1;
    check("out_valid", out_valid, m_valid);
    check("out_data", out_data, m_data);
    check("wrap", wrap, m_wrap);
  endtask

  // Asynchronous reset pulse placed between clock edges.
  task automatic async_reset();
    @(negedge clk);
    en = 1'b0; seed_load = 1'b0; out_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check("rst_valid", out_valid, 1'b0);
    check("rst_data", out_data, 8'h00);
    check("rst_wrap", wrap, 1'b0);
    check("rst_sr", dut.sr, SEED);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  int first;

  initial begin
    logic [3:0] s4;
    bit         b4;
    bit         w4;
    int         last_pulse;
    int         pulses;

    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset_valid", out_valid, 1'b0);
    check("reset_data", out_data, 8'h00);
    check("reset_wrap", wrap, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Free-running from reset: words 0x00 then 0x01.
    first = 0;
    for (int i = 1; i <= 16; i++) begin
      cycle(1'b1, 1'b0, 16'h0, 1'b1);
      if (out_valid && first == 0) first = i;
      if (i == 8)  check("word1", out_data, 8'h00);
      if (i == 16) check("word2", out_data, 8'h01);
    end
    check("first_valid_cycle", first, 8);

    // Back-pressure: generator stalls on the completing shift.
    async_reset();
    first = 0;
    for (int i = 1; i <= 20; i++) begin
      cycle(1'b1, 1'b0, 16'h0, 1'b0);
      if (out_valid && first == 0) first = i;
    end
    check("bp_first_valid", first, 8);
    check("bp_hold_data", out_data, 8'h00);
    check("bp_frozen_sr", dut.sr, m_sr);
    cycle(1'b1, 1'b0, 16'h0, 1'b1);
    check("bp_next_word", out_data, 8'h01);

    // Zero seed is replaced by SEED and replays the post-reset stream.
    cycle(1'b1, 1'b1, 16'h0000, 1'b1);
    check("zero_seed_sr", dut.sr, 16'h0001);
    check("zero_seed_ref", dut.ref_seed, 16'h0001);
    for (int i = 1; i <= 16; i++) begin
      cycle(1'b1, 1'b0, 16'h0, 1'b1);
      if (i == 8)  check("zs_word1", out_data, 8'h00);
      if (i == 16) check("zs_word2", out_data, 8'h01);
    end

    // Seed load after three bits of a word: partial bits are dropped.
    repeat (3) cycle(1'b1, 1'b0, 16'h0, 1'b1);
    cycle(1'b1, 1'b1, 16'h8000, 1'b1);
    repeat (8) cycle(1'b1, 1'b0, 16'h0, 1'b1);
    check("midload_word", out_data, 8'h80);

    // Asynchronous reset in the middle of a stall.
    repeat (20) cycle(1'b1, 1'b0, 16'h0, 1'b0);
    async_reset();

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      logic        e, ld, rdy;
      logic [15:0] sd;
      e   = ($urandom_range(0, 3) != 0);
      rdy = ($urandom_range(0, 4) < 3);
      ld  = ($urandom_range(0, 99) < 3);
      sd  = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom_range(0, 65535));
      cycle(e, ld, sd, rdy);
    end

    // 4-bit maximal-length instance, one bit per word: period of 15.
    @(negedge clk);
    rst_n_s = 1'b1; en_s = 1'b1; rdy_s = 1'b1;
    s4 = 4'h1; last_pulse = 0; pulses = 0;
    for (int c = 1; c <= 47; c++) begin
      @(posedge clk);
      b4 = s4[3];
      s4 = {s4[2:0], s4[3] ^ s4[2]};
      w4 = (s4 == 4'h1);
      #1;
      check("small_bit", data_s, b4);
      check("small_valid", valid_s, 1'b1);
      check("small_wrap", wrap_s, w4);
      if (wrap_s) begin
        check("wrap_period", c - last_pulse, 15);
        last_pulse = c;
        pulses++;
      end
    end
    check("wrap_count", pulses, 3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
